// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
//   Shared definitions for the instruction-memory program loader:
//   - loader state encoding (IDLE=0, LOAD=1, FILL=2, DONE=3, ERROR=4, 3 bits)
//   - the NOP word written into every memory location past the program
// -----------------------------------------------------------------------------
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FILL  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Instruction word used to pad unused memory after the program.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // True when a word address is the last location of a 2**aw deep memory.
  function automatic logic is_last_addr(input logic [31:0] addr, input int aw);
    return (addr == (32'(1) << aw) - 32'(1));
  endfunction

endpackage

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Writer side of the instruction-memory interface. Takes a stream of
//   instruction words over valid/ready, writes them to memory from word 0
//   upward, then pads the rest of memory with NOPs. The processor is held in
//   reset (cpu_reset_n=0) until a load finishes cleanly.
//
// Parameters
//   ADDR_WIDTH  word-address width, DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH  instruction word width
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   pulse: begin a new load (honoured in IDLE/DONE/ERROR)
//   in_valid     in   stream word valid
//   in_data      in   stream word
//   in_last      in   marks the final program word
//   in_ready     out  loader accepts a word this cycle (high only in LOAD)
//   imem_we      out  registered memory write enable
//   imem_addr    out  registered memory word address
//   imem_wdata   out  registered memory write data
//   cpu_reset_n  out  processor reset, released only in DONE
//   done         out  load finished cleanly
//   error        out  program longer than memory
//   word_count   out  program words accepted (fill words excluded)
//   checksum     out  modular sum of accepted words
// -----------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  // word_count saturation value (DEPTH) and the top memory address.
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP  = {ADDR_WIDTH{1'b1}};

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  // One bit wider than an address: the MSB set means every location has
  // been padded, which lets FILL spend one extra cycle so that done rises
  // the cycle after the final NOP write is presented.
  logic [ADDR_WIDTH:0]   fill_addr_reg;

  logic accept;
  logic at_top;

  assign in_ready = (state_reg == ST_LOAD);
  assign accept   = in_valid & in_ready;
  assign at_top   = (addr_reg == ADDR_TOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      fill_addr_reg <= '0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      cpu_reset_n   <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      word_count    <= '0;
      checksum      <= '0;
    end else begin
      // The write stage only pulses for cycles that carry a write.
      imem_we <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_reg     <= ST_LOAD;
            addr_reg      <= '0;
            fill_addr_reg <= '0;
            word_count    <= '0;
            checksum      <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_reset_n   <= 1'b0;
          end
        end

        ST_LOAD: begin
          // start is ignored here; only accepted words move the state.
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr_reg;
            imem_wdata <= in_data;
            addr_reg   <= addr_reg + ADDR_WIDTH'(1);
            checksum   <= checksum + in_data;
            if (word_count != COUNT_MAX) begin
              word_count <= word_count + (ADDR_WIDTH+1)'(1);
            end

            if (in_last) begin
              if (at_top) begin
                // Program fills memory exactly: nothing left to pad.
                state_reg   <= ST_DONE;
                done        <= 1'b1;
                cpu_reset_n <= 1'b1;
              end else begin
                state_reg     <= ST_FILL;
                fill_addr_reg <= {1'b0, addr_reg} + (ADDR_WIDTH+1)'(1);
              end
            end else if (at_top) begin
              // Memory is full and the program keeps going: the word just
              // taken is still written, then the loader refuses more.
              state_reg <= ST_ERROR;
              error     <= 1'b1;
            end
          end
        end

        ST_FILL: begin
          if (fill_addr_reg[ADDR_WIDTH]) begin
            state_reg   <= ST_DONE;
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
          end else begin
            imem_we       <= 1'b1;
            imem_addr     <= fill_addr_reg[ADDR_WIDTH-1:0];
            imem_wdata    <= DATA_WIDTH'(NOP_WORD);
            fill_addr_reg <= fill_addr_reg + (ADDR_WIDTH+1)'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
